// File: rtl/decoder_pkg.sv
// Shared widths, state encoding and decode helper for the 3-to-8 scan decoder.
package decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // Binary index to one-hot vector.
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] c);
        return ONEHOT_W'(1) << c;
    endfunction

endpackage

// File: rtl/decoder38_scan_tick_div.sv
// Scan-step prescaler: pulses tick once every DIV cycles while run is high.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count only counts while running, so a frozen counter never ticks.
    assign tick = run && (cnt_q == TERM);

    // Next count: clear wins, wrap to zero at terminal count, hold when not running.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder38_scan.sv
// 3-to-8 decoder with registered outputs: direct decode of code, or an
// auto-scan walking one that advances every DIV clocks.
module decoder38_scan
    import decoder_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_n,
    input  logic                mode,
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] y,
    output logic [CODE_W-1:0]   idx,
    output logic                valid,
    output logic                wrap
);

    state_e              state_q, state_d;
    logic                arm_q, arm_d;
    logic [ONEHOT_W-1:0] y_q, y_d;
    logic [CODE_W-1:0]   idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                wrap_q, wrap_d;
    logic                clr;
    logic                run;
    logic                tick;

    tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

    // arm_q stays low for the first edge after reset release, so the first
    // decode lands on the second edge.
    assign arm_d = 1'b1;

    // Next state and next outputs; outputs reflect the state being entered.
    always_comb begin
        state_d = (!arm_q || en_n) ? IDLE : (mode ? SCAN : DIRECT);
        idx_d   = idx_q;
        y_d     = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        clr     = 1'b0;
        run     = 1'b0;
        case (state_d)
            DIRECT: begin
                idx_d   = code;
                y_d     = onehot(code);
                valid_d = 1'b1;
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    // Scan entry: reload from code and restart the prescaler.
                    idx_d = code;
                    clr   = 1'b1;
                end else begin
                    run = 1'b1;
                    if (tick) begin
                        idx_d  = idx_q + 3'd1;
                        wrap_d = (idx_q == 3'd7);
                    end
                end
                y_d     = onehot(idx_d);
                valid_d = 1'b1;
            end
            default: begin
                // IDLE: outputs inactive, idx and prescaler hold.
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
            y_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder38_scan.sv
// Scoreboard bench for decoder38_scan, run with DIV=4 and DIV=1 side by side.
module tb_decoder38_scan;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    typedef struct {
        int         st;     // 0 idle, 1 direct, 2 scan
        bit         arm;
        logic [2:0] idx;
        int         cnt;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en_n = 1'b1;
    logic       mode = 1'b0;
    logic [2:0] code = 3'd0;

    logic [7:0] y4, y1;
    logic [2:0] idx4, idx1;
    logic       valid4, valid1, wrap4, wrap1;

    exp_t    sb4[$];
    exp_t    sb1[$];
    mstate_t m4, m1;
    int      n_checks = 0;
    int      n_fail = 0;

    decoder38_scan #(.DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .code(code),
        .y(y4), .idx(idx4), .valid(valid4), .wrap(wrap4)
    );

    decoder38_scan #(.DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .code(code),
        .y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one decoder for the coming clock edge.
    task automatic model(input int div, input mstate_t s, output mstate_t n, output exp_t e);
        n = s;
        e.y = 8'h00; e.valid = 1'b0; e.wrap = 1'b0;
        if (!s.arm || en_n) begin
            n.st = 0;
        end else if (!mode) begin
            n.st = 1;
            n.idx = code;
            e.y = 8'h01 << code; e.valid = 1'b1;
        end else begin
            n.st = 2;
            if (s.st != 2) begin
                n.idx = code;
                n.cnt = 0;
            end else if (s.cnt == div - 1) begin
                n.cnt = 0;
                n.idx = s.idx + 3'd1;
                e.wrap = (s.idx == 3'd7);
            end else begin
                n.cnt = s.cnt + 1;
            end
            e.y = 8'h01 << n.idx; e.valid = 1'b1;
        end
        n.arm = 1'b1;
        e.idx = n.idx;
    endtask

    task automatic model_reset();
        m4 = '{st: 0, arm: 1'b0, idx: 3'd0, cnt: 0};
        m1 = m4;
    endtask

    // Drive one clock: push predictions, then pop and compare after the edge.
    task automatic step();
        exp_t    e;
        mstate_t n;
        model(4, m4, n, e); m4 = n; sb4.push_back(e);
        model(1, m1, n, e); m1 = n; sb1.push_back(e);
        @(posedge clk); #1;
        if (sb4.size() == 0 || sb1.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb4.pop_front();
            chk("y4", y4, e.y); chk("idx4", idx4, e.idx);
            chk("valid4", valid4, e.valid); chk("wrap4", wrap4, e.wrap);
            e = sb1.pop_front();
            chk("y1", y1, e.y); chk("idx1", idx1, e.idx);
            chk("valid1", valid1, e.valid); chk("wrap1", wrap1, e.wrap);
            chk("onehot4", valid4 ? $onehot(y4) : (y4 == 8'h00), 1);
            chk("onehot1", valid1 ? $onehot(y1) : (y1 == 8'h00), 1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_y4"}, y4, 0);     chk({tag, "_idx4"}, idx4, 0);
        chk({tag, "_valid4"}, valid4, 0); chk({tag, "_wrap4"}, wrap4, 0);
        chk({tag, "_y1"}, y1, 0);     chk({tag, "_wrap1"}, wrap1, 0);
    endtask

    // Assert reset mid-cycle, check it acts at once, hold, release at negedge.
    task automatic do_reset(input string tag);
        #3 rst_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero({tag, "_hold"});
        @(negedge clk) rst_n = 1'b1;
    endtask

    int wraps;
    int guard;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst");

        // First decode lands on the second edge after release.
        en_n = 1'b0; mode = 1'b0; code = 3'd5;
        step();
        chk("first_edge_idle", y4, 8'h00);
        step();
        chk("second_edge_dec", y4, 8'h20);

        // Direct sweep.
        for (int c = 0; c < 8; c++) begin
            code = 3'(c);
            step();
        end

        // Disable then re-enable with code 3.
        code = 3'd3; en_n = 1'b1;
        step();
        en_n = 1'b0;
        step();
        chk("reenable_y", y4, 8'h08);

        // Scan from 6 through the wrap.
        mode = 1'b1; code = 3'd6;
        step();
        chk("scan_entry", y4, 8'h40);
        code = 3'd0;
        for (int i = 0; i < 10; i++) step();

        // DIV=1 wraps exactly twice over 16 consecutive scan steps.
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (wrap1) wraps++;
        end
        chk("div1_wraps", wraps, 2);

        // Disable mid-scan at idx 2, re-enable with code 5.
        guard = 0;
        while (!(m4.st == 2 && m4.idx == 3'd2) && guard < 40) begin
            step();
            guard++;
        end
        chk("reach_idx2", m4.idx, 3'd2);
        en_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("disabled_y", y4, 8'h00);
        en_n = 1'b0; code = 3'd5;
        step();
        chk("rescan_y", y4, 8'h20);
        for (int i = 0; i < 6; i++) step();

        // Simultaneous mode and code changes.
        mode = 1'b0; code = 3'd1; step();
        mode = 1'b1; code = 3'd4; step();
        mode = 1'b0; code = 3'd7; step();
        mode = 1'b1; code = 3'd0; step();

        // Reset just before a wrap step: no wrap pulse.
        guard = 0;
        while (!(m4.st == 2 && m4.idx == 3'd7 && m4.cnt == 3) && guard < 60) begin
            step();
            guard++;
        end
        chk("reach_prewrap", m4.idx, 3'd7);
        do_reset("rst_scan");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            en_n = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            code = 3'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder38_scan.md
DECODER38_SCAN -- requirements
Module: decoder38_scan

Interface
REQ-001 Parameter DIV, default 4: clock cycles per scan step, legal range 1..256.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en_n  input  1  active-low enable: 0 = decoding enabled, 1 = outputs forced inactive.
REQ-005 mode  input  1  0 = direct decode of code, 1 = auto-scan (walking one).
REQ-006 code  input  3  binary code to decode in direct mode; start index on scan entry.
REQ-007 y  output  8  registered one-hot output, bit k high when the decoded index is k.
REQ-008 idx  output  3  registered index currently driven on y.
REQ-009 valid  output  1  high when y holds a decoded one-hot value.
REQ-010 wrap  output  1  one-cycle pulse when a scan step takes idx from 7 to 0.

Function
REQ-011 States: IDLE (disabled), DIRECT, SCAN; state updates on each rising clk edge.
REQ-012 Any state with en_n=1 -> IDLE; IDLE with en_n=0 -> DIRECT if mode=0, else SCAN.
REQ-013 DIRECT with mode=1 -> SCAN; SCAN with mode=0 -> DIRECT (en_n=0 in both cases).
REQ-014 IDLE: y=8'h00, valid=0, wrap=0; idx and prescaler hold their values.
REQ-015 DIRECT: one-cycle latency; on the edge after code is sampled, y = 1<<code, idx = code, valid=1.
REQ-016 DIRECT: y follows code changes with one-cycle latency and no gaps.
REQ-017 Entering SCAN loads idx = code and clears the prescaler; on that edge y = 1<<code and valid=1.
REQ-018 SCAN: the prescaler counts 0..DIV-1; at terminal count idx increments modulo 8 and y = 1<<(idx+1).
REQ-019 DIV=1: idx advances on every clock in SCAN.
REQ-020 wrap=1 for exactly the cycle in which idx becomes 0 through a scan step; a load of code=0 on scan entry does not assert wrap.
REQ-021 en_n deasserted (set to 1) mid-scan: IDLE on the next edge, y=0, valid=0, prescaler frozen.
REQ-022 en_n reasserted (set to 0) with mode=1: re-entry reloads idx from code; the frozen count is discarded.
REQ-023 y is always one-hot when valid=1 and all-zero when valid=0.
REQ-024 Simultaneous change of mode and code: the new mode governs, using the new code.
REQ-025 Prescaler width is clog2(DIV), minimum 1 bit; it never exceeds DIV-1.

Reset
REQ-026 rst_n=0 asynchronously forces: state=IDLE, y=8'h00, idx=3'd0, valid=0, wrap=0, prescaler=0.
REQ-027 Reset release is sampled synchronously; the first decode occurs on the second rising edge after release with en_n=0.
REQ-028 Reset mid-scan abandons the scan; no wrap pulse is generated.

Structure
REQ-029 Shared package decoder_pkg holds CODE_W=3, ONEHOT_W=8, and the state enumeration (IDLE, DIRECT, SCAN).
REQ-030 One sub-module, tick_div (parameter DIV, inputs clk, rst_n, clr, run; output tick), generates the scan step pulse.
REQ-031 All outputs are driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-032 Reset: rst_n=0 mid-cycle -> y=0, idx=0, valid=0, wrap=0 immediately, without waiting for clk.
REQ-033 Direct sweep: en_n=0, mode=0, code=0..7 one per cycle -> y=01,02,04,...,80 each one cycle later, valid=1.
REQ-034 Disable: en_n=1 with code=3 -> next cycle y=00, valid=0; en_n=0 -> following cycle y=08.
REQ-035 Scan with DIV=4: mode=1, code=6 -> y=40, then 80 after 4 cycles, then 01 after 4 more with wrap=1 for one cycle.
REQ-036 Scan with DIV=1 -> idx steps every cycle; wrap pulses once every 8 cycles.
REQ-037 Disable mid-scan at idx=2, then re-enable with code=5 -> y=00 while disabled, then y=20 with the prescaler restarted.
